// File: rtl/gfau_pkg.sv
// Shared GFAU definitions: operand width, divider states and test prime.
package gfau_pkg;

  localparam int unsigned SIZE = 32;

  localparam logic [31:0] P256_32 = 32'hFFFF_FFFB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/gf_mod_div_if.sv
// Request/response bundle between the GFAU controller and the modular divider.
interface gf_mod_div_if
  import gfau_pkg::*;
#(
  parameter int unsigned SIZE = gfau_pkg::SIZE
) ();

  logic            i_start;
  logic [SIZE-1:0] i_a;
  logic [SIZE-1:0] i_b;
  logic [SIZE-1:0] i_prime;
  logic [SIZE-1:0] o_result;
  logic            o_done;
  logic            o_busy;
  logic            o_err;

  // Controller side issues requests and consumes results.
  modport master (
    output i_start, i_a, i_b, i_prime,
    input  o_result, o_done, o_busy, o_err
  );

  // Divider side.
  modport slave (
    input  i_start, i_a, i_b, i_prime,
    output o_result, o_done, o_busy, o_err
  );

endinterface

// File: rtl/gf_half_mod.sv
// Modular halving: returns x/2 mod p for odd p and x < p.
module gf_half_mod
  import gfau_pkg::*;
#(
  parameter int unsigned W = SIZE
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] p,
  output logic [W-1:0] half_x
);

  logic [W:0] sum;

  // Odd x gets p added first so the sum is even; the extra bit keeps x+p exact.
  always_comb begin
    sum    = {1'b0, x} + (x[0] ? {1'b0, p} : '0);
    half_x = W'(sum >> 1);
  end

endmodule

// File: rtl/gf_mod_div.sv
// Bit-serial modular divider: result = a * b^-1 mod p via binary extended Euclid.
module gf_mod_div
  import gfau_pkg::*;
#(
  parameter int unsigned SIZE = gfau_pkg::SIZE
) (
  input  logic         i_clk,
  input  logic         i_rst,
  gf_mod_div_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'(IDLE);
  localparam logic [1:0] S_RUN  = 2'(RUN);
  localparam logic [1:0] S_DONE = 2'(DONE);

  localparam logic [SIZE-1:0] ONE = SIZE'(1);

  logic [1:0]      state, state_d;
  logic [SIZE-1:0] u, u_d;
  logic [SIZE-1:0] v, v_d;
  logic [SIZE-1:0] x1, x1_d;
  logic [SIZE-1:0] x2, x2_d;
  logic [SIZE-1:0] p_reg, p_d;
  logic [SIZE-1:0] result, result_d;
  logic            err, err_d;
  logic            done, done_d;
  logic            busy, busy_d;

  logic [SIZE-1:0] x1_half, x2_half;
  logic [SIZE:0]   diff12, diff21;
  logic [SIZE-1:0] x1_sub, x2_sub;

  gf_half_mod #(.W(SIZE)) u_half_x1 (.x(x1), .p(p_reg), .half_x(x1_half));
  gf_half_mod #(.W(SIZE)) u_half_x2 (.x(x2), .p(p_reg), .half_x(x2_half));

  // Modular subtract of the Bezout coefficients; a borrow is corrected by adding p.
  always_comb begin
    diff12 = {1'b0, x1} - {1'b0, x2};
    diff21 = {1'b0, x2} - {1'b0, x1};
    x1_sub = diff12[SIZE] ? SIZE'(diff12 + {1'b0, p_reg}) : diff12[SIZE-1:0];
    x2_sub = diff21[SIZE] ? SIZE'(diff21 + {1'b0, p_reg}) : diff21[SIZE-1:0];
  end

  // Next-state and datapath update: load, one Euclid step per RUN cycle, done pulse.
  always_comb begin
    state_d  = state;
    u_d      = u;
    v_d      = v;
    x1_d     = x1;
    x2_d     = x2;
    p_d      = p_reg;
    result_d = result;
    err_d    = err;

    case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_b != '0) begin
            u_d     = bus.i_b;
            v_d     = bus.i_prime;
            x1_d    = bus.i_a;
            x2_d    = '0;
            p_d     = bus.i_prime;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            result_d = '0;
            err_d    = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (u == ONE) begin
          result_d = x1;
          state_d  = S_DONE;
        end else if (v == ONE) begin
          result_d = x2;
          state_d  = S_DONE;
        end else if (!u[0]) begin
          u_d  = u >> 1;
          x1_d = x1_half;
        end else if (!v[0]) begin
          v_d  = v >> 1;
          x2_d = x2_half;
        end else if (u >= v) begin
          u_d  = u - v;
          x1_d = x1_sub;
        end else begin
          v_d  = v - u;
          x2_d = x2_sub;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      u      <= '0;
      v      <= '0;
      x1     <= '0;
      x2     <= '0;
      p_reg  <= '0;
      result <= '0;
      err    <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_d;
      u      <= u_d;
      v      <= v_d;
      x1     <= x1_d;
      x2     <= x2_d;
      p_reg  <= p_d;
      result <= result_d;
      err    <= err_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

  assign bus.o_result = result;
  assign bus.o_err    = err;
  assign bus.o_done   = done;
  assign bus.o_busy   = busy;

  // Accepted operands must be reduced and the modulus odd.
  a_operands_legal : assert property (
    @(posedge i_clk) disable iff (i_rst)
    (state == S_IDLE && bus.i_start) |->
      (bus.i_prime[0] && bus.i_a < bus.i_prime && bus.i_b < bus.i_prime)
  );

endmodule

// File: tb/tb_gf_mod_div.sv
// Self-checking bench for gf_mod_div against a modular-exponentiation reference.
module tb_gf_mod_div;
  import gfau_pkg::*;

  localparam int unsigned MAX_CYC = 4 * SIZE + 2;
  localparam int unsigned N_RAND  = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf_mod_div_if #(.SIZE(SIZE)) bus ();

  gf_mod_div #(.SIZE(SIZE)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Quotient via Fermat: a * b^(p-2) mod p; zero divisor yields 0.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] p);
    longint unsigned r, base, e, m;
    if (b == 32'd0) return 32'd0;
    m    = 64'(p);
    r    = 64'd1;
    base = 64'(b) % m;
    e    = m - 64'd2;
    while (e != 64'd0) begin
      if (e[0]) r = (r * base) % m;
      base = (base * base) % m;
      e    = e >> 1;
    end
    return 32'((64'(a) * r) % m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_prime = p;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Waits for o_done with a bounded cycle budget; cyc counts edges since start.
  task automatic wait_done(output int cyc, output logic seen);
    cyc  = 1;
    seen = bus.o_done;
    while (!seen && cyc < int'(MAX_CYC)) begin
      tick();
      cyc++;
      seen = bus.o_done;
    end
  endtask

  task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] p, input logic full);
    int   cyc;
    logic seen;
    launch(a, b, p);
    wait_done(cyc, seen);
    check({tag, "_done"}, 64'(seen), 64'd1);
    check({tag, "_res"}, 64'(bus.o_result), 64'(ref_div(a, b, p)));
    check({tag, "_err"}, 64'(bus.o_err), 64'(b == 32'd0));
    if (full) begin
      if (b == 32'd0) check({tag, "_lat"}, 64'(cyc <= 2), 64'd1);
      tick();
      check({tag, "_pulse"}, 64'(bus.o_done), 64'd0);
      check({tag, "_idle"}, 64'(bus.o_busy), 64'd0);
    end else begin
      tick();
    end
  endtask

  initial begin
    int   cyc;
    int   dones;
    logic seen;
    logic [31:0] a, b;

    bus.i_start = 1'b0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_prime = 32'd23;
    tick();
    tick();
    check("rst_result", 64'(bus.o_result), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_err", 64'(bus.o_err), 64'd0);
    rst = 1'b0;
    tick();

    // Directed cases, including busy right after start.
    launch(32'd1, 32'd2, 32'd23);
    check("busy_after_start", 64'(bus.o_busy), 64'd1);
    wait_done(cyc, seen);
    check("p23_1_2_done", 64'(seen), 64'd1);
    check("p23_1_2_res", 64'(bus.o_result), 64'd12);
    check("p23_1_2_busy_in_done", 64'(bus.o_busy), 64'd1);
    tick();
    check("p23_1_2_pulse", 64'(bus.o_done), 64'd0);

    run_check("p23_5_3", 32'd5, 32'd3, 32'd23, 1'b1);
    check("p23_5_3_const", 64'(bus.o_result), 64'd17);
    run_check("p23_7_7", 32'd7, 32'd7, 32'd23, 1'b1);
    check("p23_7_7_const", 64'(bus.o_result), 64'd1);
    run_check("pbig_1_2", 32'd1, 32'd2, P256_32, 1'b1);
    check("pbig_1_2_const", 64'(bus.o_result), 64'h7FFF_FFFE);
    run_check("pbig_carry", 32'hFFFF_FFFA, 32'hFFFF_FFFA, P256_32, 1'b1);
    check("pbig_carry_const", 64'(bus.o_result), 64'd1);
    run_check("a_zero", 32'd0, 32'd12345, P256_32, 1'b1);
    run_check("b_zero", 32'd9, 32'd0, P256_32, 1'b1);
    run_check("b_one", 32'd9, 32'd1, P256_32, 1'b1);
    check("b_one_const", 64'(bus.o_result), 64'd9);

    // Start pulse during RUN with new operands must be ignored.
    launch(32'hFFFF_FFFA, 32'hFFFF_FFFA, P256_32);
    tick();
    bus.i_a     = 32'd5;
    bus.i_b     = 32'd3;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    wait_done(cyc, seen);
    check("ignore_done", 64'(seen), 64'd1);
    check("ignore_res", 64'(bus.o_result), 64'd1);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.o_done) dones++;
    end
    check("ignore_no_extra_done", 64'(dones), 64'd0);

    // Reset in the middle of an operation aborts it.
    launch(32'd77, 32'hFFFF_FFFA, P256_32);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    check("abort_done", 64'(bus.o_done), 64'd0);
    check("abort_result", 64'(bus.o_result), 64'd0);
    check("abort_err", 64'(bus.o_err), 64'd0);
    dones = 0;
    for (int i = 0; i < int'(MAX_CYC); i++) begin
      tick();
      if (bus.o_done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    run_check("after_abort", 32'd1234, 32'd5678, P256_32, 1'b1);

    // Random vectors against the reference, plus the defining identity.
    for (int i = 0; i < int'(N_RAND); i++) begin
      a = $urandom % P256_32;
      b = ($urandom_range(0, 31) == 0) ? 32'd0 : ($urandom % P256_32);
      run_check("rand", a, b, P256_32, 1'b0);
      if (b != 32'd0)
        check("rand_identity",
              (64'(bus.o_result) * 64'(b)) % 64'(P256_32), 64'(a));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
